el_scan_gen: RTL and testbench
==============================

# el_scan_gen

Parametrised scan-timing generator for the EL panel output path, the next generation of the current fixed-geometry output processor. It reads packed pixel words from the frame RAM and drives the panel strobes: `HS`, `VS`, the gated pixel clock and the RAM read strobe. It adds configurable geometry, a RAM read-latency window, double-buffered frame banks, frame-boundary start/stop, and a parametrised dark-screen saver that suppresses `VS`.

## Interface
- `H_ACTIVE`, 80: pixel words per line.
- `H_BLANK`, 10: blank slots per line; line period = `H_ACTIVE + H_BLANK` slots.
- `V_ACTIVE`, 240: lines per frame. No vertical blanking.
- `RD_LAT`, 1: RAM dummy-read slots before the first valid word; 0 ≤ `RD_LAT` < `H_BLANK`.
- `HS_POS`, 2: `HS` asserted in slot `x == H_ACTIVE + HS_POS`; must satisfy < `H_BLANK`.
- `ADDR_W`, 16: address width; requires 2·`H_ACTIVE`·`V_ACTIVE` ≤ 2^`ADDR_W`.
- `LIT_THRESH`, 2: pixel word counts as lit if `pix_data > LIT_THRESH`.
- `MIN_LIT`, 4: a frame with fewer lit words is dark.
- `SAVER_FRAMES`, 1000: consecutive dark frames before the saver engages.
- `clock_in`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  scan enable; sampled only at frame boundaries.
- `bank_sel`  in  1  frame bank select; sampled at frame start.
- `pix_data`  in  8  RAM read data.
- `addr`  out  `ADDR_W`  RAM read address.
- `rdPix`  out  1  RAM read strobe.
- `pixClk`  out  1  gated panel pixel clock.
- `HS`  out  1  line strobe.
- `VS`  out  1  frame strobe.
- `frame_start`  out  1  one-cycle pulse at start of each frame.
- `saver`  out  1  screensaver active.

## Operation
- State: `IDLE`, `SCAN`. Reset enters `IDLE`.
  - `IDLE` → `SCAN` on the first cycle with `run` = 1.
  - `SCAN` → `IDLE` at end of frame (x, y both maxed on a step) if `run` = 0.
  - Otherwise `SCAN` wraps to the next frame.
- Phase `ph` toggles every cycle in `SCAN` and is forced to 0 in `IDLE`. A slot is 2 cycles; a step is a `SCAN` cycle with `ph` = 1.
- On each step, x increments, wrapping at `H_ACTIVE+H_BLANK-1`. y increments when x wraps and wraps at `V_ACTIVE-1`.
- Read window: `rd_en = (x < H_ACTIVE+RD_LAT)`. Pixel window: `pix_en = (RD_LAT ≤ x < H_ACTIVE+RD_LAT)`.
- `pixClk` = `SCAN & ph & pix_en`. `rdPix` = `SCAN & ph & rd_en`.
- `addr` is registered on `SCAN` cycles with `ph` = 0 and `x < H_ACTIVE`: `addr <= bank·H_ACTIVE·V_ACTIVE + y·H_ACTIVE + x`, computed modulo 2^`ADDR_W`. Otherwise `addr` holds.
- `HS` = `SCAN & (x == H_ACTIVE+HS_POS)`. `VS` = `SCAN & (y == 0) & !saver`.
- `bank` latches `bank_sel` on the `IDLE`→`SCAN` cycle and on each frame wrap. `frame_start` pulses on those same cycles.
- Saver:
  - On every `pixClk` cycle, if `pix_data > LIT_THRESH`, `lit_cnt` increments (saturating at 2^16-1).
  - At end of frame, if `lit_cnt < MIN_LIT`, `dark_cnt` increments (saturating at `SAVER_FRAMES`); otherwise `dark_cnt` is cleared. `lit_cnt` is cleared in the same cycle.
  - `saver` = (`dark_cnt == SAVER_FRAMES`), registered. It takes effect from the next frame's first cycle, so the whole `VS` of that frame is suppressed.
  - `saver` clears at the end of the first non-dark frame.
  - Leaving `SCAN` for `IDLE` preserves `dark_cnt` and `saver`.
- Reset, at any time including mid-frame: `ph`, x, y, `addr`, `bank`, `lit_cnt`, `dark_cnt` = 0; all outputs 0; state `IDLE`.

## Timing
- `addr` is set in the `ph` = 0 cycle. `rdPix` rises in the following `ph` = 1 cycle.
- Data for address x is valid on `pix_data` at the `pixClk` high of slot x+`RD_LAT`.
- Rising `pixClk` edges per line: exactly `H_ACTIVE`. Rising `rdPix` edges per line: `H_ACTIVE+RD_LAT`.
- Frame period: 2·(`H_ACTIVE+H_BLANK`)·`V_ACTIVE` cycles; 43200 at defaults.
- `HS` high for 2 cycles per line. `VS` high for one full line of slot time.
- `run` deasserted mid-frame: the frame completes, then the block returns to `IDLE`. The next `run` starts at x = 0, y = 0, `ph` = 0.
- Simultaneous end-of-frame and `bank_sel` change: the value present on the wrap cycle is used.

## Test plan
- Reset then `run` = 1 at defaults:
  - First `frame_start` 1 cycle after `run`.
  - 80 `pixClk` pulses and 81 `rdPix` pulses per line.
  - `HS` at slot 82; frame period 43200 cycles.
- Address sweep, `bank_sel` = 1:
  - Line 3 slot 5 gives `addr` = 19200+245 = 19445.
  - Last address of the frame is 38399.
  - `addr` holds through the blank slots.
- `RD_LAT` = 3: first `pixClk` in slot 3, last in slot 82; `rdPix` spans slots 0–82.
- Saver, `SAVER_FRAMES` = 3, `pix_data` = 0:
  - `VS` is present in frames 1–3 and absent from frame 4.
  - Feed 4 words of value 5 in one frame: `saver` drops at that frame's end and `VS` returns next frame.
  - Feed only 3 lit words: `saver` stays 1.
- Drop `run` at line 100: the frame completes to y = 239, the block goes `IDLE` with all strobes 0 and `addr` holding.
- Assert `reset` at line 50 slot 40 with `saver` = 1: the next cycle shows all outputs 0, `saver` = 0, state `IDLE`.

Source files
------------

// File: rtl/el_scan_gen_if.sv
// Frame-RAM read port and EL panel strobes of the scan generator.
// Combinational bundle only: no latency and no backpressure.
interface el_scan_gen_if #(
    parameter int ADDR_W = 16
);
    logic              run;
    logic              bank_sel;
    logic [7:0]        pix_data;
    logic [ADDR_W-1:0] addr;
    logic              rdPix;
    logic              pixClk;
    logic              HS;
    logic              VS;
    logic              frame_start;
    logic              saver;

    modport master (
        input  run, bank_sel, pix_data,
        output addr, rdPix, pixClk, HS, VS, frame_start, saver
    );
    modport slave (
        output run, bank_sel, pix_data,
        input  addr, rdPix, pixClk, HS, VS, frame_start, saver
    );
endinterface

// File: rtl/el_scan_gen.sv
// EL panel scan-timing generator: raster counters, RAM reads, strobes, dark-screen saver.
// Addresses lead the read strobe by one cycle; the panel cannot stall it, so there is no backpressure.
module el_scan_gen #(
    parameter int H_ACTIVE     = 80,
    parameter int H_BLANK      = 10,
    parameter int V_ACTIVE     = 240,
    parameter int RD_LAT       = 1,
    parameter int HS_POS       = 2,
    parameter int ADDR_W       = 16,
    parameter int LIT_THRESH   = 2,
    parameter int MIN_LIT      = 4,
    parameter int SAVER_FRAMES = 1000
) (
    input logic           clock_in,
    input logic           reset,
    el_scan_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int D_W     = (SAVER_FRAMES > 0) ? $clog2(SAVER_FRAMES + 1) : 1;

    localparam logic [X_W-1:0]    X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]    X_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]    X_RDEND  = X_W'(H_ACTIVE + RD_LAT);
    localparam logic [X_W-1:0]    X_PIX0   = X_W'(RD_LAT);
    localparam logic [X_W-1:0]    X_HS     = X_W'(H_ACTIVE + HS_POS);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] BANK_OFS = ADDR_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_LEN = ADDR_W'(H_ACTIVE);
    localparam logic [7:0]        LIT_T    = 8'(LIT_THRESH);
    localparam logic [15:0]       MIN_L    = 16'(MIN_LIT);
    localparam logic [D_W-1:0]    DARK_MAX = D_W'(SAVER_FRAMES);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic              startFrame;
    logic              ph;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addrQ;
    logic [ADDR_W-1:0] addrNext;
    logic              bank;
    logic [15:0]       litCnt;
    logic [D_W-1:0]    darkCnt;
    logic [D_W-1:0]    darkNext;
    logic              saverQ;
    logic              frameStartQ;
    logic              scanning;
    logic              frameEnd;
    logic              rdEn;
    logic              pixEn;
    logic              pixClkInt;
    logic              litHit;

    assign scanning  = (state == SCAN);
    assign frameEnd  = scanning & ph & (x == X_LAST) & (y == Y_LAST);
    assign rdEn      = (x < X_RDEND);
    assign pixEn     = (x >= X_PIX0) & (x < X_RDEND);
    assign pixClkInt = scanning & ph & pixEn;
    assign litHit    = pixClkInt & (bus.pix_data > LIT_T);
    assign addrNext  = (bank ? BANK_OFS : '0) + ADDR_W'(y) * LINE_LEN + ADDR_W'(x);

    // A frame with too few lit words pushes the dark count toward the saver limit.
    assign darkNext = (litCnt < MIN_L)
                    ? ((darkCnt == DARK_MAX) ? darkCnt : darkCnt + 1'b1)
                    : '0;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // run is only honoured in IDLE or on the last step of a frame.
    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    stateNext  = SCAN;
                    startFrame = 1'b1;
                end
            end
            SCAN: begin
                if (frameEnd) begin
                    if (bus.run) begin
                        startFrame = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            ph          <= 1'b0;
            x           <= '0;
            y           <= '0;
            addrQ       <= '0;
            bank        <= 1'b0;
            litCnt      <= '0;
            darkCnt     <= '0;
            saverQ      <= 1'b0;
            frameStartQ <= 1'b0;
        end else begin
            frameStartQ <= startFrame;
            if (startFrame) begin
                bank <= bus.bank_sel;
            end
            if (scanning) begin
                ph <= ~ph;
                if (!ph && (x < X_ACT)) begin
                    addrQ <= addrNext;
                end
                if (ph) begin
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= (y == Y_LAST) ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end else begin
                ph <= 1'b0;
            end
            // The last slot of a frame is always blank, so no lit word is lost here.
            if (frameEnd) begin
                litCnt  <= '0;
                darkCnt <= darkNext;
                saverQ  <= (darkNext == DARK_MAX);
            end else if (litHit && (litCnt != '1)) begin
                litCnt <= litCnt + 1'b1;
            end
        end
    end

    assign bus.addr        = addrQ;
    assign bus.rdPix       = scanning & ph & rdEn;
    assign bus.pixClk      = pixClkInt;
    assign bus.HS          = scanning & (x == X_HS);
    assign bus.VS          = scanning & (y == '0) & ~saverQ;
    assign bus.frame_start = frameStartQ;
    assign bus.saver       = saverQ;
endmodule

// File: tb/tb_el_scan_gen.sv
// Three el_scan_gen instances (defaults, RD_LAT=3, small saver geometry) checked against a raster model.
module tb_el_scan_gen;
    localparam int N = 3;

    typedef struct {
        int h, hb, v, rl, hsp, aw, lt, ml, sf;
    } geo_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd, pc, hs, vs, fs, sv;
    } out_t;

    function automatic geo_t geo(int i);
        geo_t g;
        g = '{h: 80, hb: 10, v: 240, rl: 1, hsp: 2, aw: 16, lt: 2, ml: 4, sf: 1000};
        if (i == 1) g.rl = 3;
        if (i == 2) g = '{h: 8, hb: 4, v: 4, rl: 1, hsp: 2, aw: 8, lt: 2, ml: 4, sf: 3};
        return g;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       in_rst  [N];
    logic       in_run  [N];
    logic       in_bsel [N];
    logic [7:0] in_pix  [N];
    out_t       dut_o   [N];
    bit         done    [N];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         finished = 0;

    el_scan_gen_if #(.ADDR_W(16)) if0 ();
    el_scan_gen_if #(.ADDR_W(16)) if1 ();
    el_scan_gen_if #(.ADDR_W(8))  if2 ();

    assign if0.run = in_run[0];  assign if0.bank_sel = in_bsel[0];  assign if0.pix_data = in_pix[0];
    assign if1.run = in_run[1];  assign if1.bank_sel = in_bsel[1];  assign if1.pix_data = in_pix[1];
    assign if2.run = in_run[2];  assign if2.bank_sel = in_bsel[2];  assign if2.pix_data = in_pix[2];
    assign dut_o[0] = {if0.addr, if0.rdPix, if0.pixClk, if0.HS, if0.VS, if0.frame_start, if0.saver};
    assign dut_o[1] = {if1.addr, if1.rdPix, if1.pixClk, if1.HS, if1.VS, if1.frame_start, if1.saver};
    assign dut_o[2] = {8'h00, if2.addr, if2.rdPix, if2.pixClk, if2.HS, if2.VS, if2.frame_start, if2.saver};

    el_scan_gen u0 (.clock_in(clk), .reset(in_rst[0]), .bus(if0));
    el_scan_gen #(.RD_LAT(3)) u1 (.clock_in(clk), .reset(in_rst[1]), .bus(if1));
    el_scan_gen #(.H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .RD_LAT(1), .HS_POS(2),
                  .ADDR_W(8), .SAVER_FRAMES(3)) u2 (.clock_in(clk), .reset(in_rst[2]), .bus(if2));

    // Model: position inside the frame is derived from elapsed cycles since frame start.
    bit m_scan [N];
    int m_t    [N];
    int m_bank [N];
    int m_addr [N];
    int m_lit  [N];
    int m_dark [N];
    bit m_sv   [N];
    bit m_fs   [N];

    function automatic out_t expect_out(int i);
        geo_t g  = geo(i);
        int   lp = g.h + g.hb;
        int   x  = (m_t[i] / 2) % lp;
        int   y  = m_t[i] / (2 * lp);
        bit   ph = (m_t[i] % 2) == 1;
        out_t o;
        o.addr = 16'(m_addr[i]);
        o.rd   = m_scan[i] && ph && (x < g.h + g.rl);
        o.pc   = m_scan[i] && ph && (x >= g.rl) && (x < g.h + g.rl);
        o.hs   = m_scan[i] && (x == g.h + g.hsp);
        o.vs   = m_scan[i] && (y == 0) && !m_sv[i];
        o.fs   = m_fs[i];
        o.sv   = m_sv[i];
        return o;
    endfunction

    task automatic model_step(int i);
        geo_t g  = geo(i);
        int   lp = g.h + g.hb;
        int   fp = 2 * lp * g.v;
        int   x  = (m_t[i] / 2) % lp;
        int   y  = m_t[i] / (2 * lp);
        bit   ph = (m_t[i] % 2) == 1;
        if (in_rst[i]) begin
            m_scan[i] = 0; m_t[i] = 0; m_bank[i] = 0; m_addr[i] = 0;
            m_lit[i] = 0; m_dark[i] = 0; m_sv[i] = 0; m_fs[i] = 0;
        end else if (!m_scan[i]) begin
            m_fs[i] = in_run[i];
            if (in_run[i]) begin
                m_scan[i] = 1; m_t[i] = 0; m_bank[i] = in_bsel[i] ? 1 : 0;
            end
        end else begin
            m_fs[i] = 0;
            if (ph && x >= g.rl && x < g.h + g.rl && int'(in_pix[i]) > g.lt && m_lit[i] < 65535)
                m_lit[i]++;
            if (!ph && x < g.h)
                m_addr[i] = (m_bank[i] * g.h * g.v + y * g.h + x) % (1 << g.aw);
            if (m_t[i] == fp - 1) begin
                m_dark[i] = (m_lit[i] < g.ml) ? ((m_dark[i] < g.sf) ? m_dark[i] + 1 : g.sf) : 0;
                m_lit[i]  = 0;
                m_sv[i]   = (m_dark[i] == g.sf);
                m_t[i]    = 0;
                if (in_run[i]) begin
                    m_fs[i] = 1; m_bank[i] = in_bsel[i] ? 1 : 0;
                end else begin
                    m_scan[i] = 0;
                end
            end else begin
                m_t[i]++;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) model_step(i);
        cyc++;
    end

    task automatic finish_bench();
        if (!finished) begin
            finished = 1;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    endtask

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                out_t e;
                e = expect_out(i);
                checks++;
                if (dut_o[i] !== e) begin
                    failures++;
                    $display("FAIL model_cmp inst%0d cycle %0d: got %h expected %h", i, cyc, dut_o[i], e);
                end
            end
            if (failures >= 100) finish_bench();
        end
    end

    task automatic wait_fs(int i, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!dut_o[i].fs && waited < 50);
    endtask

    // Defaults, bank 1: strobe counts on line 0, HS slot, address sweep, frame period.
    initial begin : stim0
        int   wc, npc, nrd, nhs, nvs;
        out_t me;
        in_rst[0] = 1; in_run[0] = 0; in_bsel[0] = 1; in_pix[0] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs_inst0", longint'(dut_o[0]), 0);
        in_rst[0] = 0;
        @(negedge clk);
        in_run[0] = 1;
        wait_fs(0, wc);
        chk("first_fs_latency_inst0", wc, 1);
        npc = 0; nrd = 0; nhs = 0; nvs = 0;
        for (int c = 0; c <= 43200; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 180) begin
                npc += int'(dut_o[0].pc); nrd += int'(dut_o[0].rd); nhs += int'(dut_o[0].hs);
            end
            if (c < 43200) nvs += int'(dut_o[0].vs);
            case (c)
                163:   chk("hs_before_slot82", dut_o[0].hs, 0);
                164:   chk("hs_slot82_ph0", dut_o[0].hs, 1);
                165:   chk("hs_slot82_ph1", dut_o[0].hs, 1);
                166:   chk("hs_after_slot82", dut_o[0].hs, 0);
                551: begin
                    chk("addr_line3_slot5", dut_o[0].addr, 19445);
                    me = expect_out(0);
                    chk("model_addr_line3_slot5", me.addr, 19445);
                end
                710:   chk("addr_hold_blank", dut_o[0].addr, 19519);
                43179: chk("addr_last_word", dut_o[0].addr, 38399);
                43199: begin
                    chk("addr_hold_frame_end", dut_o[0].addr, 38399);
                    chk("no_fs_before_period", dut_o[0].fs, 0);
                end
                43200: chk("fs_after_43200", dut_o[0].fs, 1);
                default: ;
            endcase
        end
        chk("pixclk_per_line", npc, 80);
        chk("rdpix_per_line", nrd, 81);
        chk("hs_cycles_per_line", nhs, 2);
        chk("vs_cycles_per_frame", nvs, 180);
        done[0] = 1;
    end

    // RD_LAT=3, bank 0: read/pixel windows, then run dropped at line 100.
    initial begin : stim1
        int wc, fpc, lpc, frd, lrd, npc, nrd, tpc, trd;
        in_rst[1] = 1; in_run[1] = 0; in_bsel[1] = 0; in_pix[1] = 8'h10;
        repeat (3) @(negedge clk);
        chk("reset_outs_inst1", longint'(dut_o[1]), 0);
        in_rst[1] = 0;
        @(negedge clk);
        in_run[1] = 1;
        wait_fs(1, wc);
        chk("first_fs_latency_inst1", wc, 1);
        fpc = -1; lpc = -1; frd = -1; lrd = -1; npc = 0; nrd = 0; tpc = 0; trd = 0;
        for (int c = 0; c <= 43210; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 180) begin
                if (dut_o[1].pc) begin if (fpc < 0) fpc = c; lpc = c; npc++; end
                if (dut_o[1].rd) begin if (frd < 0) frd = c; lrd = c; nrd++; end
            end
            if (c < 43200) begin
                tpc += int'(dut_o[1].pc); trd += int'(dut_o[1].rd);
            end
            if (c == 18000) in_run[1] = 0;
            if (c >= 43200) begin
                chk("idle_strobes_zero",
                    {dut_o[1].pc, dut_o[1].rd, dut_o[1].hs, dut_o[1].vs, dut_o[1].fs}, 0);
                chk("idle_addr_hold", dut_o[1].addr, 19199);
            end
        end
        chk("rdlat3_first_pixclk", fpc, 7);
        chk("rdlat3_last_pixclk", lpc, 165);
        chk("rdlat3_first_rdpix", frd, 1);
        chk("rdlat3_last_rdpix", lrd, 165);
        chk("rdlat3_pixclk_line", npc, 80);
        chk("rdlat3_rdpix_line", nrd, 83);
        chk("frame_pixclk_total", tpc, 19200);
        chk("frame_rdpix_total", trd, 19920);
        done[1] = 1;
    end

    // Small geometry, SAVER_FRAMES=3: saver engage, release on 4 lit words, hold on 3, reset.
    initial begin : stim2
        int wc, nvs;
        int exp_vs [1:9]  = '{24, 24, 24, 0, 0, 24, 24, 24, 0};
        bit exp_sv [1:10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
        bit lit;
        in_rst[2] = 1; in_run[2] = 0; in_bsel[2] = 0; in_pix[2] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs_inst2", longint'(dut_o[2]), 0);
        in_rst[2] = 0;
        @(negedge clk);
        in_run[2] = 1;
        wait_fs(2, wc);
        chk("first_fs_latency_inst2", wc, 1);
        for (int f = 1; f <= 10; f++) begin
            nvs = 0;
            for (int c = 0; c < 96; c++) begin
                if (!(f == 1 && c == 0)) @(negedge clk);
                if (c == 0) begin
                    chk($sformatf("fs_frame%0d", f), dut_o[2].fs, 1);
                    chk($sformatf("saver_frame%0d", f), dut_o[2].sv, exp_sv[f]);
                end
                if (f == 5 && c == 95) chk("saver_held_to_frame5_end", dut_o[2].sv, 1);
                nvs += int'(dut_o[2].vs);
                lit = (f == 5 && c >= 3 && c <= 9) || (f == 9 && c >= 3 && c <= 7);
                in_pix[2] = lit ? 8'd5 : ((f == 2 || f == 7) ? 8'd2 : 8'd0);
                if (f == 10 && c == 58) begin
                    chk("saver_before_reset", dut_o[2].sv, 1);
                    in_rst[2] = 1;
                    in_run[2] = 0;
                    break;
                end
            end
            if (f < 10) chk($sformatf("vs_cycles_frame%0d", f), nvs, exp_vs[f]);
        end
        @(negedge clk);
        chk("outs_after_midframe_reset", longint'(dut_o[2]), 0);
        in_rst[2] = 0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_after_reset", longint'(dut_o[2]), 0);
        end
        done[2] = 1;
    end

    initial begin : main
        for (int k = 0; k < 50000 && !(done[0] && done[1] && done[2]); k++) @(negedge clk);
        if (!(done[0] && done[1] && done[2])) begin
            checks++;
            failures++;
            $display("FAIL timeout: done=%0d%0d%0d expected 111", done[0], done[1], done[2]);
        end
        finish_bench();
    end
endmodule
